rf_operand_fetch: RTL

//  Read-side client of the register file: accepts decoded source/dest register fields and

---
 rtl/rf_operand_fetch_if.sv | 41 ++++
 rtl/rf_operand_fetch.sv | 113 +++++++++++
 2 files changed

// File: rtl/rf_operand_fetch_if.sv
// Bundle between decode, the register file read/write ports and the operand consumer.
// The slave side belongs to rf_operand_fetch; master is the surrounding pipeline.
interface rf_operand_fetch_if #(
    parameter int REG_WIDTH = 32,
    parameter int REG_DEPTH = 32
);
    localparam int AW = $clog2(REG_DEPTH);

    logic                 i_ReqValid;
    logic                 o_ReqReady;
    logic [AW-1:0]        i_Rs1;
    logic [AW-1:0]        i_Rs2;
    logic [AW-1:0]        i_Rd;
    logic                 i_RdWrite;
    logic [AW-1:0]        o_Addr1;
    logic [AW-1:0]        o_Addr2;
    logic [REG_WIDTH-1:0] i_RD1;
    logic [REG_WIDTH-1:0] i_RD2;
    logic                 i_WbValid;
    logic [AW-1:0]        i_WbAddr;
    logic [REG_WIDTH-1:0] i_WbData;
    logic                 i_Flush;
    logic                 o_OpValid;
    logic                 i_OpReady;
    logic [REG_WIDTH-1:0] o_Op1;
    logic [REG_WIDTH-1:0] o_Op2;
    logic [AW-1:0]        o_Rd;
    logic                 o_Busy;

    modport master (
        output i_ReqValid, i_Rs1, i_Rs2, i_Rd, i_RdWrite,
        output i_RD1, i_RD2, i_WbValid, i_WbAddr, i_WbData, i_Flush, i_OpReady,
        input  o_ReqReady, o_Addr1, o_Addr2, o_OpValid, o_Op1, o_Op2, o_Rd, o_Busy
    );

    modport slave (
        input  i_ReqValid, i_Rs1, i_Rs2, i_Rd, i_RdWrite,
        input  i_RD1, i_RD2, i_WbValid, i_WbAddr, i_WbData, i_Flush, i_OpReady,
        output o_ReqReady, o_Addr1, o_Addr2, o_OpValid, o_Op1, o_Op2, o_Rd, o_Busy
    );
endinterface

// File: rtl/rf_operand_fetch.sv
// Operand fetch: scoreboard-checked register reads with same-edge writeback bypass,
// one request in flight, operands held on a valid/ready handshake.
module rf_operand_fetch #(
    parameter int REG_WIDTH = 32,
    parameter int REG_DEPTH = 32
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    rf_operand_fetch_if.slave   bus
);
    localparam int AW = $clog2(REG_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    typedef struct packed {
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          rd_write;
    } req_t;

    logic [1:0]           state, state_nxt;
    req_t                 req;
    logic [REG_DEPTH-1:0] sb, sb_nxt;
    logic                 hit1, hit2;
    logic [REG_WIDTH-1:0] wb_data;
    logic [REG_WIDTH-1:0] op1, op2;
    logic [AW-1:0]        op_rd;

    logic                 accept, go_read, rd_tracked, wb_live;
    logic                 haz1, haz2, hazd, hazard;
    logic [REG_WIDTH-1:0] op1_sel, op2_sel;

    assign wb_live    = bus.i_WbValid && (bus.i_WbAddr != '0);
    assign rd_tracked = req.rd_write && (req.rd != '0);

    // A writeback landing on the check edge resolves the hazard it would have caused.
    assign haz1 = (req.rs1 != '0) && sb[req.rs1] && !(bus.i_WbValid && bus.i_WbAddr == req.rs1);
    assign haz2 = (req.rs2 != '0) && sb[req.rs2] && !(bus.i_WbValid && bus.i_WbAddr == req.rs2);
    assign hazd = rd_tracked && sb[req.rd] && !(bus.i_WbValid && bus.i_WbAddr == req.rd);
    assign hazard = haz1 || haz2 || hazd;

    assign accept  = (state == IDLE) && bus.i_ReqValid && !bus.i_Flush;
    assign go_read = (state == CHECK) && !hazard && !bus.i_Flush;

    always_comb begin
        state_nxt = state;
        if (bus.i_Flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.i_ReqValid) state_nxt = CHECK;
                CHECK:   if (!hazard) state_nxt = READ;
                READ:    state_nxt = HOLD;
                HOLD:    if (bus.i_OpReady) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Ordering matters: set after clears so a new claim beats a retiring write.
    always_comb begin
        sb_nxt = sb;
        if (wb_live) sb_nxt[bus.i_WbAddr] = 1'b0;
        if (bus.i_Flush && (state == READ || state == HOLD) && rd_tracked) sb_nxt[req.rd] = 1'b0;
        if (go_read && rd_tracked) sb_nxt[req.rd] = 1'b1;
        sb_nxt[0] = 1'b0;
    end

    assign op1_sel = (req.rs1 == '0) ? '0 : (hit1 ? wb_data : bus.i_RD1);
    assign op2_sel = (req.rs2 == '0) ? '0 : (hit2 ? wb_data : bus.i_RD2);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= IDLE;
            req     <= '0;
            sb      <= '0;
            hit1    <= 1'b0;
            hit2    <= 1'b0;
            wb_data <= '0;
            op1     <= '0;
            op2     <= '0;
            op_rd   <= '0;
        end else begin
            state <= state_nxt;
            sb    <= sb_nxt;
            if (accept) req <= {bus.i_Rs1, bus.i_Rs2, bus.i_Rd, bus.i_RdWrite};
            // The file returns pre-write data for a write on the read edge; remember it here.
            if (go_read) begin
                hit1    <= bus.i_WbValid && (bus.i_WbAddr == req.rs1);
                hit2    <= bus.i_WbValid && (bus.i_WbAddr == req.rs2);
                wb_data <= bus.i_WbData;
            end
            if (state == READ && !bus.i_Flush) begin
                op1   <= op1_sel;
                op2   <= op2_sel;
                op_rd <= req.rd;
            end
        end
    end

    assign bus.o_ReqReady = (state == IDLE);
    assign bus.o_OpValid  = (state == HOLD);
    assign bus.o_Addr1    = req.rs1;
    assign bus.o_Addr2    = req.rs2;
    assign bus.o_Op1      = op1;
    assign bus.o_Op2      = op2;
    assign bus.o_Rd       = op_rd;
    assign bus.o_Busy     = |sb;
endmodule
